// File: rtl/dmem_stage.sv
// MEM-stage data memory interface: issues one request per load/store, stalls the
// pipeline until ack or timeout, and presents load data to the MEM/WB register.
`timescale 1ns/1ps
module dmem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        memread_i,
    input  logic        memwrite_i,
    input  logic        memtoreg_i,
    input  logic        regwrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  RD_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic [31:0] data_o,
    output logic [31:0] result_o,
    output logic [4:0]  RD_o,
    output logic        memtoreg_o,
    output logic        regwrite_o,
    output logic        err_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic [31:0] ldata;
    logic        op, misaligned, start, timeout;

    assign op         = memread_i | memwrite_i;
    assign misaligned = op & (addr_i[1:0] != 2'b00);
    assign start      = (state == IDLE) & op & ~misaligned;
    assign timeout    = (cnt == 8'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; acks outside BUSY are ignored
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (mem_ack_i || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        stall_o = 1'b0;
        data_o  = 32'h0;
        case (state)
            IDLE:    stall_o = op & ~misaligned;
            BUSY:    stall_o = 1'b1;
            DONE:    data_o  = ldata;
            default: stall_o = 1'b0;
        endcase
    end

    // Request registers, wait counter, load data and sticky error
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'h0;
            mem_wdata_o <= 32'h0;
            cnt         <= 8'h0;
            ldata       <= 32'h0;
            err_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr_o  <= addr_i;
                        mem_wdata_o <= wdata_i;
                        mem_we_o    <= memwrite_i;
                        mem_req_o   <= 1'b1;
                        cnt         <= 8'h0;
                    end
                    if (misaligned) err_o <= 1'b1;
                end
                BUSY: begin
                    // ack wins over a coincident timeout
                    if (mem_ack_i) begin
                        ldata     <= mem_we_o ? 32'h0 : mem_rdata_i;
                        mem_req_o <= 1'b0;
                    end else if (timeout) begin
                        ldata     <= 32'h0;
                        mem_req_o <= 1'b0;
                        err_o     <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_o   = addr_i;
    assign RD_o       = RD_i;
    assign memtoreg_o = memtoreg_i;
    assign regwrite_o = regwrite_i & ~stall_o & ~misaligned;

endmodule

// File: tb/tb_dmem_stage.sv
// Transaction-level bench for dmem_stage: each instruction's stall length, request
// window, load data and error are predicted from the access rules and checked per cycle.
`timescale 1ns/1ps
module tb_dmem_stage;
    localparam int unsigned TO = 4;

    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        memread_i = 0, memwrite_i = 0, memtoreg_i = 0, regwrite_i = 0;
    logic [31:0] addr_i = 0, wdata_i = 0, mem_rdata_i = 0;
    logic [4:0]  RD_i = 0;
    logic        mem_ack_i = 0;
    logic        mem_req_o, mem_we_o, stall_o, memtoreg_o, regwrite_o, err_o;
    logic [31:0] mem_addr_o, mem_wdata_o, data_o, result_o;
    logic [4:0]  RD_o;

    int n_vec = 0, n_err = 0;
    bit err_model = 0;

    dmem_stage #(.TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .memread_i(memread_i), .memwrite_i(memwrite_i),
        .memtoreg_i(memtoreg_i), .regwrite_i(regwrite_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .RD_i(RD_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o), .data_o(data_o), .result_o(result_o), .RD_o(RD_o),
        .memtoreg_o(memtoreg_o), .regwrite_o(regwrite_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_pass(input string tag);
        chk({tag, ".result"}, result_o, addr_i);
        chk({tag, ".rd"}, {27'h0, RD_o}, {27'h0, RD_i});
        chk({tag, ".mtr"}, {31'h0, memtoreg_o}, {31'h0, memtoreg_i});
    endtask

    // One instruction held at the MEM stage until it retires.
    // ack_lat: BUSY cycle (1-based) in which ack arrives; 0 or > TO means never.
    task automatic run_op(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rdata,
                          input int ack_lat, input bit stray);
        bit mis, aligned_op, acked;
        int nbusy;
        logic [31:0] exp_data;
        mis        = (rd | wr) && (addr[1:0] != 2'b00);
        aligned_op = (rd | wr) && !mis;
        acked      = (ack_lat >= 1) && (ack_lat <= int'(TO));
        nbusy      = acked ? ack_lat : int'(TO);
        exp_data   = (acked && !wr) ? rdata : 32'h0;

        memread_i = rd; memwrite_i = wr; addr_i = addr; wdata_i = wd;
        RD_i = 5'($urandom); memtoreg_i = 1'($urandom); regwrite_i = 1'($urandom);
        mem_ack_i = stray; mem_rdata_i = $urandom;
        @(negedge clk_i);
        chk("idle.stall", {31'h0, stall_o}, {31'h0, aligned_op});
        chk("idle.req", {31'h0, mem_req_o}, 32'h0);
        chk("idle.data", data_o, 32'h0);
        chk("idle.regwr", {31'h0, regwrite_o}, {31'h0, regwrite_i & !aligned_op & !mis});
        chk("idle.err", {31'h0, err_o}, {31'h0, err_model});
        chk_pass("idle");
        @(posedge clk_i); #1;
        mem_ack_i = 0;
        if (!aligned_op) begin
            err_model |= mis;
            return;
        end
        for (int j = 1; j <= nbusy; j++) begin
            mem_ack_i   = (j == ack_lat);
            mem_rdata_i = (j == ack_lat) ? rdata : $urandom;
            @(negedge clk_i);
            chk("busy.req", {31'h0, mem_req_o}, 32'h1);
            chk("busy.we", {31'h0, mem_we_o}, {31'h0, wr});
            chk("busy.addr", mem_addr_o, addr);
            chk("busy.wdata", mem_wdata_o, wd);
            chk("busy.stall", {31'h0, stall_o}, 32'h1);
            chk("busy.regwr", {31'h0, regwrite_o}, 32'h0);
            @(posedge clk_i); #1;
            mem_ack_i = 0;
        end
        if (!acked) err_model = 1;
        mem_ack_i = 1'($urandom);
        mem_rdata_i = $urandom;
        @(negedge clk_i);
        chk("done.req", {31'h0, mem_req_o}, 32'h0);
        chk("done.stall", {31'h0, stall_o}, 32'h0);
        chk("done.data", data_o, exp_data);
        chk("done.regwr", {31'h0, regwrite_o}, {31'h0, regwrite_i});
        chk("done.err", {31'h0, err_o}, {31'h0, err_model});
        chk_pass("done");
        @(posedge clk_i); #1;
        mem_ack_i = 0;
    endtask

    initial begin
        #12;
        chk("rst.req", {31'h0, mem_req_o}, 32'h0);
        chk("rst.we", {31'h0, mem_we_o}, 32'h0);
        chk("rst.addr", mem_addr_o, 32'h0);
        chk("rst.wdata", mem_wdata_o, 32'h0);
        chk("rst.err", {31'h0, err_o}, 32'h0);
        chk("rst.data", data_o, 32'h0);
        chk("rst.stall", {31'h0, stall_o}, 32'h0);
        @(negedge clk_i); rst_i = 0;
        @(posedge clk_i); #1;

        // directed scenarios
        run_op(1, 0, 32'h100, 32'h0, 32'hDEADBEEF, 2, 0);
        run_op(0, 1, 32'h200, 32'h12345678, 32'hCAFEF00D, 1, 0);
        run_op(1, 1, 32'h300, 32'hA5A5A5A5, 32'h11111111, 3, 0);
        run_op(1, 0, 32'h104, 32'h0, 32'h22222222, int'(TO), 0);
        run_op(0, 0, 32'h40, 32'h0, 32'h0, 0, 1);
        run_op(1, 0, 32'h102, 32'h0, 32'h0, 1, 0);
        run_op(1, 0, 32'h400, 32'h0, 32'h33333333, 0, 0);
        run_op(0, 0, 32'h44, 32'h0, 32'h0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(3, 0) != 0) a[1:0] = 2'b00;
            run_op(1'($urandom), 1'($urandom), a, $urandom, $urandom,
                   int'($urandom_range(6, 0)), 1'($urandom));
        end

        // reset in the 2nd BUSY cycle abandons the access
        memread_i = 1; memwrite_i = 0; addr_i = 32'h500; mem_ack_i = 0;
        @(posedge clk_i); @(posedge clk_i); #2;
        rst_i = 1; #1;
        chk("arst.req", {31'h0, mem_req_o}, 32'h0);
        chk("arst.err", {31'h0, err_o}, 32'h0);
        chk("arst.data", data_o, 32'h0);
        chk("arst.stall", {31'h0, stall_o}, 32'h1);
        memread_i = 0; #1;
        chk("arst.stall_noop", {31'h0, stall_o}, 32'h0);
        err_model = 0;
        @(negedge clk_i); rst_i = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            chk("arst.noreq", {31'h0, mem_req_o}, 32'h0);
            chk("arst.nostall", {31'h0, stall_o}, 32'h0);
        end
        @(posedge clk_i); #1;
        run_op(1, 0, 32'h600, 32'h0, 32'h44444444, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
